prog_delay_line: RTL and testbench
==================================

Name: prog_delay_line

Overview:
Runtime-programmable delay line. Successor to the fixed-depth shift-register delay buffer.
- Adds a per-entry valid tag, a synchronous clear, and a delay selectable at runtime from 1 to MAX_DEPTH enables.
- Storage is a circular buffer with a write pointer, not a physical shift chain.
- Sits in the datapath wherever operands must be aligned with a pipeline of variable latency.

Parameters:
- MAX_DEPTH, 16, storage entries and maximum delay in enables. Must be ≥2; need not be a power of 2.
- BITS, 64, data width.
- DLY_W, $clog2(MAX_DEPTH+1), width of the delay value. Derived; not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  advance: write d/d_valid and step the line by one.
- clr  input  1  synchronous flush of all entries and the pointer.
- delay_set  input  1  load delay_in as the new delay. Implies a flush.
- delay_in  input  DLY_W  requested delay. Legal range is 1..MAX_DEPTH.
- d  input  BITS  data in.
- d_valid  input  1  valid tag stored with d.
- q  output  BITS  data written exactly `delay` enables ago.
- q_valid  output  1  valid tag of q.
- delay  output  DLY_W  currently active delay.
- err  output  1  one-cycle pulse when delay_set carries an illegal delay_in.

Behaviour:
- State:
  - mem[MAX_DEPTH] of BITS bits.
  - vld[MAX_DEPTH] of 1 bit.
  - wr_ptr, range 0..MAX_DEPTH-1, pointing at the next slot to write.
  - delay register.
  - err flop.
- Reset (async):
  - all mem = 0, all vld = 0, wr_ptr = 0.
  - delay = MAX_DEPTH, err = 0.
  - Outputs therefore read q = 0, q_valid = 0.
- Read path is combinational from current state; there are no registered outputs besides err.
  - rd_idx = (wr_ptr − delay) mod MAX_DEPTH.
  - q = mem[rd_idx], q_valid = vld[rd_idx].
  - With delay = MAX_DEPTH, rd_idx = wr_ptr. The slot is read before it is overwritten.
- Priority per cycle: clr > delay_set > en. Only the highest active action takes effect.
- clr:
  - mem = 0, vld = 0, wr_ptr = 0. delay is unchanged.
  - err = 0 that cycle. Any en or delay_set in the same cycle is ignored.
- delay_set with 1 ≤ delay_in ≤ MAX_DEPTH:
  - delay = delay_in and an identical flush (mem, vld, wr_ptr cleared).
  - en in the same cycle is ignored.
- delay_set with delay_in = 0 or delay_in > MAX_DEPTH:
  - delay, mem, vld and wr_ptr are unchanged.
  - err = 1 for exactly the next cycle.
  - en in the same cycle is still ignored.
- err behaviour: err = 0 on every cycle without an illegal delay_set. Back-to-back illegal loads hold err high.
- en (no clr or delay_set):
  - mem[wr_ptr] = d, vld[wr_ptr] = d_valid.
  - wr_ptr = wr_ptr+1, wrapping from MAX_DEPTH-1 to 0.
- en = 0: state holds and q/q_valid are stable. Delay counts enables, not cycles.
- Latency:
  - After the N-th enable since the last flush, with N ≥ delay: q = d of enable N−delay+1.
  - For N < delay: q = 0 and q_valid = 0.
- A d_valid = 0 bubble re-emerges as q_valid = 0 exactly `delay` enables later.
- Reset asserted mid-stream overrides everything immediately.
  - Operation resumes on the first clk edge after deassertion, with delay = MAX_DEPTH.

Test Plan:
1. Reset with defaults:
   - Response: q = 0, q_valid = 0, delay = 16, err = 0.
   - Hold en = 0 for 5 cycles; outputs stay unchanged.
2. Default delay 16: en = 1, d = k, d_valid = 1 for k = 1..40 consecutive cycles.
   - After writes 1..15: q_valid = 0.
   - After write k ≥ 16: q = k−15, q_valid = 1, including across wr_ptr wrap.
3. delay_set with delay_in = 3:
   - Next cycle: q_valid = 0 and delay = 3.
   - Write d = 0xA, 0xB, 0xC, 0xD. After the 3rd write q = 0xA valid; after the 4th, q = 0xB.
   - Insert 4 idle cycles with en = 0; q stays 0xB.
4. Illegal loads: delay_set with delay_in = 0, then delay_in = 17.
   - err pulses 1 cycle each.
   - delay, q and q_valid are unchanged, and stream alignment continues unchanged afterwards.
5. Delay 1 with a bubble: write 0x5 valid, 0x6 invalid, 0x7 valid.
   - q sequence: 0x5/1, 0x6/0, 0x7/1. Each appears one enable after its write.
   - Run 50 writes to exercise wrap.
6. Simultaneous events and reset mid-stream:
   - clr + delay_set + en in one cycle: delay unchanged, line flushed, no write.
   - delay_set + en: new delay loaded, no write.
   - rst_n asserted mid-stream: q = 0 and q_valid = 0 immediately; delay = 16 after release.

Source files
------------

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: circular buffer of data + valid tags, read
// `delay` enables behind the write pointer, with synchronous flush and delay load.
module prog_delay_line #(
  parameter  int MAX_DEPTH = 16,
  parameter  int BITS      = 64,
  localparam int DLY_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             delay_set,
  input  logic [DLY_W-1:0] delay_in,
  input  logic [BITS-1:0]  d,
  input  logic             d_valid,
  output logic [BITS-1:0]  q,
  output logic             q_valid,
  output logic [DLY_W-1:0] delay,
  output logic             err
);

  localparam int PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int CW    = DLY_W + 1;

  logic [BITS-1:0]      r_mem [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [DLY_W-1:0]     r_delay;
  logic                 r_err;

  logic                 w_legal;
  logic [CW-1:0]        w_sum;
  logic [PTR_W-1:0]     w_rd_idx;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_legal = (delay_in != '0) && (delay_in <= DLY_W'(MAX_DEPTH));

  // Biasing by MAX_DEPTH keeps the subtraction non-negative; delay never exceeds it.
  assign w_sum    = CW'(r_wr_ptr) + CW'(MAX_DEPTH) - CW'(r_delay);
  assign w_rd_idx = (w_sum >= CW'(MAX_DEPTH)) ? PTR_W'(w_sum - CW'(MAX_DEPTH))
                                              : PTR_W'(w_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DEPTH; i++) r_mem[i] <= '0;
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_delay  <= DLY_W'(MAX_DEPTH);
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (clr) begin
        for (int i = 0; i < MAX_DEPTH; i++) r_mem[i] <= '0;
        r_vld    <= '0;
        r_wr_ptr <= '0;
      end else if (delay_set) begin
        // An illegal value leaves the line untouched and only raises err.
        if (w_legal) begin
          r_delay <= delay_in;
          for (int i = 0; i < MAX_DEPTH; i++) r_mem[i] <= '0;
          r_vld    <= '0;
          r_wr_ptr <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (en) begin
        r_mem[r_wr_ptr] <= d;
        r_vld[r_wr_ptr] <= d_valid;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
    end
  end

  assign q       = r_mem[w_rd_idx];
  assign q_valid = r_vld[w_rd_idx];
  assign delay   = r_delay;
  assign err     = r_err;

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: table-driven vectors, hand sequences and a
// randomized stream checked against a history-queue reference model.
module tb_prog_delay_line;

  localparam int MAX_DEPTH = 16;
  localparam int BITS      = 64;
  localparam int DLY_W     = $clog2(MAX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, clr, delay_set, d_valid;
  logic [DLY_W-1:0] delay_in;
  logic [BITS-1:0]  d;
  logic [BITS-1:0]  q;
  logic             q_valid, err;
  logic [DLY_W-1:0] delay;

  int nchk = 0;
  int nerr = 0;

  prog_delay_line #(.MAX_DEPTH(MAX_DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .delay_set(delay_set),
    .delay_in(delay_in), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .delay(delay), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: everything written since the last flush, oldest first.
  logic [BITS:0] hist[$];
  int            m_delay;
  bit            m_err;

  function automatic void model_reset();
    hist.delete();
    m_delay = MAX_DEPTH;
    m_err   = 1'b0;
  endfunction

  function automatic void model_step(bit c, bit ds, int di, bit e, logic [BITS-1:0] dd, bit dv);
    m_err = 1'b0;
    if (c) hist.delete();
    else if (ds) begin
      if (di >= 1 && di <= MAX_DEPTH) begin
        m_delay = di;
        hist.delete();
      end else m_err = 1'b1;
    end else if (e) hist.push_back({dv, dd});
  endfunction

  function automatic logic [BITS:0] model_out();
    int n = hist.size();
    if (n >= m_delay) return hist[n - m_delay];
    return '0;
  endfunction

  task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [BITS:0] m = model_out();
    check({tag, ".q"}, q, m[BITS-1:0]);
    check({tag, ".q_valid"}, BITS'(q_valid), BITS'(m[BITS]));
    check({tag, ".delay"}, BITS'(delay), BITS'(m_delay));
    check({tag, ".err"}, BITS'(err), BITS'(m_err));
  endtask

  task automatic step(input string tag, input bit c, input bit ds, input int di,
                      input bit e, input logic [BITS-1:0] dd, input bit dv);
    clr = c; delay_set = ds; delay_in = DLY_W'(di); en = e; d = dd; d_valid = dv;
    @(posedge clk); #1;
    model_step(c, ds, di, e, dd, dv);
    clr = 1'b0; delay_set = 1'b0; en = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    bit        ds;
    int        di;
    bit        e;
    logic [7:0] dd;
    logic [7:0] eq;
    bit        eqv;
    int        edly;
    bit        eerr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; en = 0; clr = 0; delay_set = 0; delay_in = '0; d = '0; d_valid = 0;
    model_reset();

    // Delay 3 stream, idle hold, illegal loads (incl. back-to-back), alignment kept.
    tbl = '{
      '{1, 3,  0, 8'h00, 8'h00, 0, 3, 0},
      '{0, 0,  1, 8'h0A, 8'h00, 0, 3, 0},
      '{0, 0,  1, 8'h0B, 8'h00, 0, 3, 0},
      '{0, 0,  1, 8'h0C, 8'h0A, 1, 3, 0},
      '{0, 0,  1, 8'h0D, 8'h0B, 1, 3, 0},
      '{0, 0,  0, 8'h00, 8'h0B, 1, 3, 0},
      '{0, 0,  0, 8'h00, 8'h0B, 1, 3, 0},
      '{0, 0,  0, 8'h00, 8'h0B, 1, 3, 0},
      '{0, 0,  0, 8'h00, 8'h0B, 1, 3, 0},
      '{1, 0,  1, 8'h77, 8'h0B, 1, 3, 1},
      '{0, 0,  0, 8'h00, 8'h0B, 1, 3, 0},
      '{1, 17, 1, 8'h77, 8'h0B, 1, 3, 1},
      '{1, 0,  0, 8'h00, 8'h0B, 1, 3, 1},
      '{0, 0,  0, 8'h00, 8'h0B, 1, 3, 0},
      '{0, 0,  1, 8'h0E, 8'h0C, 1, 3, 0},
      '{0, 0,  1, 8'h0F, 8'h0D, 1, 3, 0}
    };

    // 1: reset state and idle hold
    #12;
    check("rst.q", q, '0);
    check("rst.q_valid", BITS'(q_valid), '0);
    check("rst.delay", BITS'(delay), BITS'(MAX_DEPTH));
    check("rst.err", BITS'(err), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, '0, 0);

    // 2: default delay 16 across the pointer wrap
    for (int k = 1; k <= 40; k++) begin
      step("def16", 0, 0, 0, 1, BITS'(k), 1);
      if (k >= 16) check("def16.exp_q", q, BITS'(k - 15));
      check("def16.exp_qv", BITS'(q_valid), BITS'(k >= 16));
    end

    // 3/4: table
    for (int i = 0; i < tbl.size(); i++) begin
      step("tbl", 0, tbl[i].ds, tbl[i].di, tbl[i].e, BITS'(tbl[i].dd), 1);
      check($sformatf("tbl%0d.q", i), q, BITS'(tbl[i].eq));
      check($sformatf("tbl%0d.qv", i), BITS'(q_valid), BITS'(tbl[i].eqv));
      check($sformatf("tbl%0d.delay", i), BITS'(delay), BITS'(tbl[i].edly));
      check($sformatf("tbl%0d.err", i), BITS'(err), BITS'(tbl[i].eerr));
    end

    // 5: delay 1 with a bubble, then wrap
    step("d1.set", 0, 1, 1, 0, '0, 0);
    step("d1.w5", 0, 0, 0, 1, 64'h5, 1);
    check("d1.q5", q, 64'h5); check("d1.v5", BITS'(q_valid), 1);
    step("d1.w6", 0, 0, 0, 1, 64'h6, 0);
    check("d1.q6", q, 64'h6); check("d1.v6", BITS'(q_valid), 0);
    step("d1.w7", 0, 0, 0, 1, 64'h7, 1);
    check("d1.q7", q, 64'h7); check("d1.v7", BITS'(q_valid), 1);
    for (int i = 0; i < 50; i++)
      step("d1.wrap", 0, 0, 0, 1, {$urandom, $urandom}, 1'($urandom));

    // 6: simultaneous events
    step("sim.clr_all", 1, 1, 5, 1, 64'hDEAD, 1);
    check("sim.clr_delay", BITS'(delay), 1);
    check("sim.clr_qv", BITS'(q_valid), 0);
    step("sim.w", 0, 0, 0, 1, 64'h99, 1);
    check("sim.w_q", q, 64'h99);
    step("sim.set_en", 0, 1, 4, 1, 64'hBEEF, 1);
    check("sim.set_delay", BITS'(delay), 4);
    for (int i = 0; i < 4; i++) step("sim.after", 0, 0, 0, 1, BITS'(64'h100 + i), 1);
    check("sim.first", q, 64'h100);

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      bit c  = (r < 3);
      bit ds = (r >= 3 && r < 8);
      int di = $urandom_range(0, (1 << DLY_W) - 1);
      step("rnd", c, ds, di, 1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom));
    end

    // Reset mid-stream is immediate; delay returns to default
    step("pre_rst", 0, 1, 2, 0, '0, 0);
    for (int i = 0; i < 3; i++) step("pre_rst.w", 0, 0, 0, 1, BITS'(64'h50 + i), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.q", q, '0);
    check("midrst.q_valid", BITS'(q_valid), '0);
    check("midrst.delay", BITS'(delay), BITS'(MAX_DEPTH));
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) step("post_rst", 0, 0, 0, 1, BITS'(i + 1), 1);
    check("post_rst.q", q, 64'h5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
